// File: rtl/lv_bist_ctrl.sv
// -----------------------------------------------------------------------------
// lv_bist_ctrl
//
// Sequencer for the LV logic BIST engine.
//
// A start request first waits a settle interval. The sequencer then enables the
// engine and waits for its done flag. It evaluates the three sub-results and
// re-runs the engine after a low-enable gap when any of them failed, up to
// MAX_RETRY extra runs. The final outcome is held as sticky pass/fail status
// together with an error code, for the register map.
//
// Optional build macro:
//   LV_BIST_AUTO_START_EN - a one-shot implicit start fires on the 2nd cycle
//                           after reset release. It re-arms only on reset.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_bist_start            start request pulse (ignored while busy)
//   i_bist_abort            abort request pulse (only acts while busy)
//   o_bist_en               registered enable to the BIST engine
//   i_lv_bist_done          engine done level, valid while enable is high
//   i_owt_bist_rult         1 = OWT loopback pass
//   i_scan_reg_bist_rult    1 = scan-register error
//   i_hv_intb_bist_rult     1 = HV INTB check error
//   o_bist_busy             high in SETTLE/RUN/EVAL/GAP
//   o_bist_pass/o_bist_fail sticky final status, never both high
//   o_bist_err_code         [0] owt fail [1] scan err [2] intb err [3] timeout
//   o_bist_retry_cnt        retries consumed in the current/last sequence
//   o_bist_cmplt            one-cycle pulse on entry to PASS or FAIL
//   o_dbg_state             current FSM state, for observation only
//
// Request protocol: start and abort are single-cycle pulses. They are sampled
// on the rising clock edge and need no acknowledge. A request that does not
// apply in the current state is dropped. Abort has priority over start.
// -----------------------------------------------------------------------------
module lv_bist_ctrl #(
   parameter int SETTLE_CYC = 96,
   parameter int GAP_CYC    = 48,
   parameter int MAX_RETRY  = 2,
   parameter int DONE_TMO   = 131072
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_bist_start,
   input  logic       i_bist_abort,
   output logic       o_bist_en,
   input  logic       i_lv_bist_done,
   input  logic       i_owt_bist_rult,
   input  logic       i_scan_reg_bist_rult,
   input  logic       i_hv_intb_bist_rult,
   output logic       o_bist_busy,
   output logic       o_bist_pass,
   output logic       o_bist_fail,
   output logic [3:0] o_bist_err_code,
   output logic [1:0] o_bist_retry_cnt,
   output logic       o_bist_cmplt,
   output logic [2:0] o_dbg_state
);

   localparam int CNT_MAX_A = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
   localparam int CNT_MAX   = (CNT_MAX_A > DONE_TMO) ? CNT_MAX_A : DONE_TMO;
   localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   // Terminal count of each timed state (the counter starts at 0 on entry).
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYC - 1);
   localparam logic [CW-1:0] TMO_LAST    = CW'(DONE_TMO - 1);
   localparam logic [RW-1:0] RETRY_LIM   = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_RUN    = 3'd2,
      S_EVAL   = 3'd3,
      S_GAP    = 3'd4,
      S_PASS   = 3'd5,
      S_FAIL   = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [RW-1:0]   retry_q, retry_d;
   logic [3:0]      err_q, err_d;
   logic            pass_q, pass_d;
   logic            fail_q, fail_d;
   logic            en_q;
   logic            cmplt_q;
   logic            busy;
   logic            start_req;
   logic [3:0]      eval_err;

`ifdef LV_BIST_AUTO_START_EN
   // Counts the first cycles after reset release and then parks at 3. The
   // value 1 marks the 2nd cycle, so the implicit start fires exactly once.
   logic [1:0] auto_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         auto_q <= 2'd0;
      end else if (auto_q != 2'd3) begin
         auto_q <= auto_q + 2'd1;
      end
   end

   assign start_req = i_bist_start | (auto_q == 2'd1);
`else
   assign start_req = i_bist_start;
`endif

   assign busy = (state_q == S_SETTLE) || (state_q == S_RUN) ||
                 (state_q == S_EVAL)   || (state_q == S_GAP);

   // Bit 0 is inverted because the OWT result reports pass, not error.
   assign eval_err = {1'b0, i_hv_intb_bist_rult, i_scan_reg_bist_rult,
                      ~i_owt_bist_rult};

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      err_d   = err_q;
      pass_d  = pass_q;
      fail_d  = fail_q;

      if (busy && i_bist_abort) begin
         state_d = S_IDLE;
         pass_d  = 1'b0;
         fail_d  = 1'b0;
         err_d   = 4'd0;
      end else begin
         case (state_q)
            S_IDLE, S_PASS, S_FAIL: begin
               if (start_req) begin
                  state_d = S_SETTLE;
                  pass_d  = 1'b0;
                  fail_d  = 1'b0;
                  err_d   = 4'd0;
                  retry_d = '0;
               end
            end
            S_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               // Done is checked first so it wins over a simultaneous timeout.
               if (i_lv_bist_done) begin
                  state_d = S_EVAL;
               end else if (cnt_q == TMO_LAST) begin
                  state_d = S_FAIL;
                  fail_d  = 1'b1;
                  err_d   = 4'b1000;
               end
            end
            S_EVAL: begin
               if (eval_err == 4'd0) begin
                  state_d = S_PASS;
                  pass_d  = 1'b1;
                  err_d   = 4'd0;
               end else if (retry_q < RETRY_LIM) begin
                  state_d = S_GAP;
                  retry_d = retry_q + RW'(1);
               end else begin
                  state_d = S_FAIL;
                  fail_d  = 1'b1;
                  err_d   = eval_err;
               end
            end
            S_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  state_d = S_RUN;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         retry_q <= '0;
         err_q   <= 4'd0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         en_q    <= 1'b0;
         cmplt_q <= 1'b0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
         err_q   <= err_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         // The shared counter restarts on every state change and saturates.
         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
         end
         // Enable is computed from the next state, so it rises on the first
         // RUN cycle and falls on the first cycle after RUN/EVAL.
         en_q    <= (state_d == S_RUN) || (state_d == S_EVAL);
         cmplt_q <= ((state_d == S_PASS) && (state_q != S_PASS)) ||
                    ((state_d == S_FAIL) && (state_q != S_FAIL));
      end
   end

   generate
      if (RW >= 2) begin : g_retry_trunc
         assign o_bist_retry_cnt = retry_q[1:0];
      end else begin : g_retry_ext
         assign o_bist_retry_cnt = {1'b0, retry_q};
      end
   endgenerate

   assign o_bist_en       = en_q;
   assign o_bist_busy     = busy;
   assign o_bist_pass     = pass_q;
   assign o_bist_fail     = fail_q;
   assign o_bist_err_code = err_q;
   assign o_bist_cmplt    = cmplt_q;
   assign o_dbg_state     = state_q;

endmodule
